// File: rtl/dispatch_byte_serializer_if.sv
// dispatch_byte_serializer_if: packet-in / byte-out handshake bundle with FIFO status.
interface dispatch_byte_serializer_if #(
  parameter int PKT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                            pkt_valid;
  logic                            pkt_ready;
  logic [PKT_WIDTH-1:0]            pkt;
  logic                            byte_valid;
  logic                            byte_ready;
  logic [7:0]                      byte_data;
  logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy;
  logic                            busy;
  modport master (
    output pkt_valid, pkt, byte_ready,
    input  pkt_ready, byte_valid, byte_data, occupancy, busy
  );
  modport slave (
    input  pkt_valid, pkt, byte_ready,
    output pkt_ready, byte_valid, byte_data, occupancy, busy
  );
endinterface

// File: rtl/dispatch_byte_serializer.sv
// dispatch_byte_serializer: FIFO-buffered dispatch packets emitted MSB-byte-first on a byte stream.
module dispatch_byte_serializer #(
  parameter int PKT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic arst,
  dispatch_byte_serializer_if.slave bus
);
  localparam int NB = (PKT_WIDTH + 7) / 8;
  localparam int SW = NB * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t               state_q, state_d;
  logic [SW-1:0]        sr_q, sr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rdy_q, rdy_d;
  logic [PKT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                 push, pop, fire, last;
  always_comb begin
    push    = bus.pkt_valid && rdy_q;
    fire    = (state_q == SEND) && bus.byte_ready;
    last    = idx_q == IW'(NB - 1);
    pop     = (cnt_q != '0) && ((state_q == IDLE) || (fire && last));
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    if (pop) begin
      state_d = SEND;
      sr_d    = SW'(mem_q[rd_q]);
      idx_d   = '0;
    end else if (fire) begin
      state_d = last ? IDLE : SEND;
      sr_d    = sr_q << 8;
      idx_d   = idx_q + IW'(1);
    end
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // registered ready keeps byte_ready off the pkt_ready path
    rdy_d = cnt_d < CW'(FIFO_DEPTH);
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.pkt;
  end
  assign bus.pkt_ready  = rdy_q;
  assign bus.byte_valid = state_q == SEND;
  assign bus.byte_data  = (state_q == SEND) ? sr_q[SW-1 -: 8] : 8'h00;
  assign bus.occupancy  = cnt_q;
  assign bus.busy       = (state_q == SEND) || (cnt_q != '0);
endmodule
